// File: rtl/cpu_mmio_axil_bridge_pkg.sv
// Shared definitions for the CPU MMIO to AXI4-Lite bridge: response codes,
// FSM state encoding and response classification.
package cpu_mmio_axil_bridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_WR_B   = 3'd2,
      ST_RD_A   = 3'd3,
      ST_RD_D   = 3'd4,
      ST_RD_RET = 3'd5
   } bridge_state_e;

   // Anything other than OKAY, EXOKAY included, is reported as an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/cpu_mmio_axil_bridge_bus_watchdog.sv
// Saturating response watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it.
module bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last_s;

   // Next count: clear wins, otherwise count up and stick at the last value.
   always_comb begin
      at_last_s = (cnt_q == CNT_LAST);
      cnt_d     = cnt_q;
      if (clear_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable_i && !at_last_s) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && !clear_i && at_last_s;

endmodule

// File: rtl/cpu_mmio_axil_bridge.sv
// Single-outstanding CPU load/store to AXI4-Lite master bridge with a response
// watchdog and sticky first-error capture.
module cpu_mmio_axil_bridge
   import cpu_mmio_axil_bridge_pkg::*;
#(
   parameter int         ADDR_WIDTH     = 32,
   parameter int         DATA_WIDTH     = 32,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [2:0] AXI_PROT       = 3'b000
) (
   input  logic                    system_clk,
   input  logic                    system_reset,
   input  logic [ADDR_WIDTH-1:0]   Address,
   input  logic                    MemWrite,
   input  logic                    MemRead,
   input  logic [DATA_WIDTH-1:0]   Write_data,
   input  logic [DATA_WIDTH/8-1:0] Write_strb,
   output logic                    Mem_Req_Ready,
   output logic [DATA_WIDTH-1:0]   Read_data,
   output logic                    Read_data_Valid,
   input  logic                    Read_data_Ready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    bus_err,
   output logic                    bus_timeout,
   output logic [ADDR_WIDTH-1:0]   err_addr
);

   localparam int STRB_W = DATA_WIDTH / 8;

   bridge_state_e           state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    aw_done_q;
   logic                    w_done_q;
   logic                    bready_q;
   logic                    arvalid_q;
   logic                    rready_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    rd_valid_q;
   logic                    req_ready_q;
   logic                    bus_err_q;
   logic                    bus_timeout_q;
   logic [ADDR_WIDTH-1:0]   err_addr_q;

   logic accept_s;
   logic aw_hs_s;
   logic w_hs_s;
   logic b_hs_s;
   logic ar_hs_s;
   logic r_hs_s;
   logic aw_fin_s;
   logic w_fin_s;
   logic leave_s;
   logic wd_idle_s;
   logic wd_clear_s;
   logic wd_enable_s;
   logic wd_expired_s;
   logic err_evt_s;
   logic can_capture_s;

   assign accept_s      = req_ready_q & (MemWrite | MemRead);
   assign aw_hs_s       = awvalid_q & awready;
   assign w_hs_s        = wvalid_q & wready;
   assign b_hs_s        = bready_q & bvalid;
   assign ar_hs_s       = arvalid_q & arready;
   assign r_hs_s        = rready_q & rvalid;
   assign aw_fin_s      = aw_done_q | aw_hs_s;
   assign w_fin_s       = w_done_q | w_hs_s;
   assign wd_idle_s     = (state_q == ST_IDLE) || (state_q == ST_RD_RET);
   assign wd_clear_s    = wd_idle_s | leave_s;
   assign wd_enable_s   = ~wd_idle_s;
   assign err_evt_s     = (b_hs_s & resp_is_err(bresp)) | (r_hs_s & resp_is_err(rresp));
   assign can_capture_s = ~bus_err_q & ~bus_timeout_q;

   // Detects the cycle in which the FSM will move to another state.
   always_comb begin
      leave_s = 1'b0;
      case (state_q)
         ST_IDLE:   leave_s = accept_s;
         ST_WR:     leave_s = aw_fin_s & w_fin_s;
         ST_WR_B:   leave_s = b_hs_s;
         ST_RD_A:   leave_s = ar_hs_s;
         ST_RD_D:   leave_s = r_hs_s;
         ST_RD_RET: leave_s = Read_data_Ready;
         default:   leave_s = 1'b1;
      endcase
   end

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (system_clk),
      .rst_i     (system_reset),
      .clear_i   (wd_clear_s),
      .enable_i  (wd_enable_s),
      .expired_o (wd_expired_s)
   );

   // Bridge FSM with all channel, CPU-side and sticky status registers.
   always_ff @(posedge system_clk) begin
      if (system_reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= {ADDR_WIDTH{1'b0}};
         wdata_q       <= {DATA_WIDTH{1'b0}};
         wstrb_q       <= {STRB_W{1'b0}};
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rd_data_q     <= {DATA_WIDTH{1'b0}};
         rd_valid_q    <= 1'b0;
         req_ready_q   <= 1'b1;
         bus_err_q     <= 1'b0;
         bus_timeout_q <= 1'b0;
         err_addr_q    <= {ADDR_WIDTH{1'b0}};
      end else begin
         if (err_evt_s) begin
            bus_err_q <= 1'b1;
         end
         if (wd_expired_s) begin
            bus_timeout_q <= 1'b1;
         end
         // Only the first error or timeout since reset records its address.
         if ((err_evt_s || wd_expired_s) && can_capture_s) begin
            err_addr_q <= addr_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  addr_q      <= Address;
                  wdata_q     <= Write_data;
                  wstrb_q     <= Write_strb;
                  req_ready_q <= 1'b0;
                  if (MemWrite) begin
                     state_q   <= ST_WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                  end else begin
                     state_q   <= ST_RD_A;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (aw_hs_s) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs_s) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (aw_fin_s && w_fin_s) begin
                  state_q  <= ST_WR_B;
                  bready_q <= 1'b1;
               end
            end
            ST_WR_B: begin
               if (b_hs_s) begin
                  state_q     <= ST_IDLE;
                  bready_q    <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            ST_RD_A: begin
               if (ar_hs_s) begin
                  state_q   <= ST_RD_D;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            ST_RD_D: begin
               if (r_hs_s) begin
                  state_q    <= ST_RD_RET;
                  rready_q   <= 1'b0;
                  rd_data_q  <= rdata;
                  rd_valid_q <= 1'b1;
               end
            end
            ST_RD_RET: begin
               if (Read_data_Ready) begin
                  state_q     <= ST_IDLE;
                  rd_valid_q  <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               awvalid_q   <= 1'b0;
               wvalid_q    <= 1'b0;
               bready_q    <= 1'b0;
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               rd_valid_q  <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign Mem_Req_Ready   = req_ready_q;
   assign Read_data       = rd_data_q;
   assign Read_data_Valid = rd_valid_q;
   assign awaddr          = addr_q;
   assign awprot          = AXI_PROT;
   assign awvalid         = awvalid_q;
   assign wdata           = wdata_q;
   assign wstrb           = wstrb_q;
   assign wvalid          = wvalid_q;
   assign bready          = bready_q;
   assign araddr          = addr_q;
   assign arprot          = AXI_PROT;
   assign arvalid         = arvalid_q;
   assign rready          = rready_q;
   assign bus_err         = bus_err_q;
   assign bus_timeout     = bus_timeout_q;
   assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_cpu_mmio_axil_bridge.sv
// Directed bench for cpu_mmio_axil_bridge; the AXI slave side is driven cycle by cycle.
module tb_cpu_mmio_axil_bridge;

   logic        system_clk = 1'b0;
   logic        system_reset = 1'b0;
   logic [31:0] Address = 32'h0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] Write_data = 32'h0;
   logic [3:0]  Write_strb = 4'h0;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready = 1'b0;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready = 1'b1;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready = 1'b1;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b1;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        bus_err;
   logic        bus_timeout;
   logic [31:0] err_addr;

   int checks = 0;
   int errors = 0;
   int b_hs_cnt = 0;

   cpu_mmio_axil_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .AXI_PROT(3'b000)
   ) dut (
      .system_clk(system_clk), .system_reset(system_reset),
      .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
      .Write_data(Write_data), .Write_strb(Write_strb),
      .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
      .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .bus_err(bus_err), .bus_timeout(bus_timeout), .err_addr(err_addr)
   );

   always #5 system_clk = ~system_clk;

   always @(posedge system_clk) begin
      if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
   end

   task automatic tick;
      @(posedge system_clk);
      #1;
   endtask

   task automatic test_reset;
      system_reset = 1'b1;
      tick;
      tick;
      system_reset = 1'b0;
      checks++;
      if ({Mem_Req_Ready, awvalid, wvalid, bready, arvalid, rready, Read_data_Valid, bus_err, bus_timeout} !== 9'b100000000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 100000000", {Mem_Req_Ready, awvalid, wvalid, bready, arvalid, rready, Read_data_Valid, bus_err, bus_timeout});
      end
      checks++;
      if (Read_data !== 32'h0 || err_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got rd=%h ea=%h want 0 0", Read_data, err_addr);
      end
   endtask

   task automatic test_write_zero_wait;
      int b0;
      b0 = b_hs_cnt;
      Address = 32'h1000_0004; Write_data = 32'hA5A5_1234; Write_strb = 4'hF; MemWrite = 1'b1;
      tick;
      MemWrite = 1'b0; Address = 32'hFFFF_FFFF; Write_data = 32'h0; Write_strb = 4'h0;
      checks++;
      if ({awvalid, wvalid, arvalid, Mem_Req_Ready, bready} !== 5'b11000) begin
         errors++;
         $display("FAIL wr0_c1_ctrl got %b want 11000", {awvalid, wvalid, arvalid, Mem_Req_Ready, bready});
      end
      checks++;
      if (awaddr !== 32'h1000_0004 || wdata !== 32'hA5A5_1234 || wstrb !== 4'hF || awprot !== 3'b000) begin
         errors++;
         $display("FAIL wr0_payload got %h %h %h %b want 10000004 a5a51234 f 000", awaddr, wdata, wstrb, awprot);
      end
      tick;
      checks++;
      if ({awvalid, wvalid, bready, Mem_Req_Ready} !== 4'b0010) begin
         errors++;
         $display("FAIL wr0_c2_ctrl got %b want 0010", {awvalid, wvalid, bready, Mem_Req_Ready});
      end
      bvalid = 1'b1; bresp = 2'b00;
      tick;
      bvalid = 1'b0;
      checks++;
      if ({Mem_Req_Ready, bready, bus_err} !== 3'b100) begin
         errors++;
         $display("FAIL wr0_c3_done got %b want 100", {Mem_Req_Ready, bready, bus_err});
      end
      checks++;
      if (b_hs_cnt !== b0 + 1) begin
         errors++;
         $display("FAIL wr0_b_count got %0d want %0d", b_hs_cnt - b0, 1);
      end
   endtask

   task automatic test_write_wready_delay;
      int b0;
      b0 = b_hs_cnt;
      wready = 1'b0;
      Address = 32'h1000_0010; Write_data = 32'h0BAD_CAFE; Write_strb = 4'h3; MemWrite = 1'b1;
      tick;
      MemWrite = 1'b0;
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++;
         $display("FAIL wrd_c1 got %b want 11", {awvalid, wvalid});
      end
      tick;
      for (int c = 2; c <= 5; c++) begin
         checks++;
         if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL wrd_wait_c%0d got %b %h want 010 0badcafe", c, {awvalid, wvalid, bready}, wdata);
         end
         if (c == 5) wready = 1'b1;
         tick;
      end
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         errors++;
         $display("FAIL wrd_c6 got %b want 001", {awvalid, wvalid, bready});
      end
      bvalid = 1'b1;
      tick;
      bvalid = 1'b0;
      checks++;
      if (Mem_Req_Ready !== 1'b1) begin
         errors++;
         $display("FAIL wrd_ready got %b want 1", Mem_Req_Ready);
      end
      tick;
      checks++;
      if (b_hs_cnt !== b0 + 1 || bus_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wrd_b_once got %0d to=%b want 1 0", b_hs_cnt - b0, bus_timeout);
      end
   endtask

   task automatic test_read_hold;
      Address = 32'h1000_0008; MemRead = 1'b1;
      tick;
      MemRead = 1'b0; Address = 32'h0;
      checks++;
      if ({arvalid, awvalid, wvalid} !== 3'b100 || araddr !== 32'h1000_0008 || arprot !== 3'b000) begin
         errors++;
         $display("FAIL rd_c1 got %b %h want 100 10000008", {arvalid, awvalid, wvalid}, araddr);
      end
      tick;
      checks++;
      if ({arvalid, rready} !== 2'b01) begin
         errors++;
         $display("FAIL rd_c2 got %b want 01", {arvalid, rready});
      end
      rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
      tick;
      rvalid = 1'b0; rdata = 32'h5555_AAAA;
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if ({Read_data_Valid, Mem_Req_Ready, rready} !== 3'b100 || Read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rd_hold_c%0d got %b %h want 100 cafef00d", c, {Read_data_Valid, Mem_Req_Ready, rready}, Read_data);
         end
         if (c == 6) Read_data_Ready = 1'b1;
         tick;
      end
      Read_data_Ready = 1'b0;
      checks++;
      if ({Read_data_Valid, Mem_Req_Ready} !== 2'b01) begin
         errors++;
         $display("FAIL rd_release got %b want 01", {Read_data_Valid, Mem_Req_Ready});
      end
   endtask

   task automatic test_write_read_collision;
      Address = 32'h1000_0020; Write_data = 32'h1111_2222; Write_strb = 4'hF;
      MemWrite = 1'b1; MemRead = 1'b1;
      tick;
      MemWrite = 1'b0; MemRead = 1'b0;
      checks++;
      if ({awvalid, wvalid, arvalid} !== 3'b110) begin
         errors++;
         $display("FAIL col_c1 got %b want 110", {awvalid, wvalid, arvalid});
      end
      tick;
      checks++;
      if ({arvalid, bready} !== 2'b01) begin
         errors++;
         $display("FAIL col_c2 got %b want 01", {arvalid, bready});
      end
      bvalid = 1'b1;
      tick;
      bvalid = 1'b0;
      MemRead = 1'b1;
      tick;
      MemRead = 1'b0;
      checks++;
      if ({arvalid, awvalid} !== 2'b10 || araddr !== 32'h1000_0020) begin
         errors++;
         $display("FAIL col_reread got %b %h want 10 10000020", {arvalid, awvalid}, araddr);
      end
      tick;
      rvalid = 1'b1; rdata = 32'h1357_9BDF;
      tick;
      rvalid = 1'b0;
      checks++;
      if (Read_data_Valid !== 1'b1 || Read_data !== 32'h1357_9BDF) begin
         errors++;
         $display("FAIL col_rdata got %b %h want 1 13579bdf", Read_data_Valid, Read_data);
      end
      Read_data_Ready = 1'b1;
      tick;
      Read_data_Ready = 1'b0;
   endtask

   task automatic test_bus_error;
      Address = 32'h2000_0000; Write_data = 32'h0000_00FF; Write_strb = 4'h1; MemWrite = 1'b1;
      tick;
      MemWrite = 1'b0;
      tick;
      bvalid = 1'b1; bresp = 2'b10;
      tick;
      bvalid = 1'b0; bresp = 2'b00;
      checks++;
      if ({bus_err, bus_timeout, Mem_Req_Ready} !== 3'b101 || err_addr !== 32'h2000_0000) begin
         errors++;
         $display("FAIL err_slverr got %b %h want 101 20000000", {bus_err, bus_timeout, Mem_Req_Ready}, err_addr);
      end
      Address = 32'h2000_0004; MemRead = 1'b1;
      tick;
      MemRead = 1'b0;
      tick;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
      tick;
      rvalid = 1'b0; rresp = 2'b00;
      checks++;
      if ({Read_data_Valid, bus_err} !== 2'b11 || Read_data !== 32'hDEAD_BEEF || err_addr !== 32'h2000_0000) begin
         errors++;
         $display("FAIL err_decerr got %b %h %h want 11 deadbeef 20000000", {Read_data_Valid, bus_err}, Read_data, err_addr);
      end
      Read_data_Ready = 1'b1;
      tick;
      Read_data_Ready = 1'b0;
   endtask

   task automatic test_reset_mid_read;
      arready = 1'b0;
      Address = 32'h4000_0000; MemRead = 1'b1;
      tick;
      MemRead = 1'b0;
      tick;
      checks++;
      if (arvalid !== 1'b1 || bus_err !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre got ar=%b err=%b want 1 1", arvalid, bus_err);
      end
      system_reset = 1'b1;
      tick;
      system_reset = 1'b0; arready = 1'b1;
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, Read_data_Valid, bus_err, bus_timeout, Mem_Req_Ready} !== 9'b000000001 || err_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid got %b %h want 000000001 0", {awvalid, wvalid, arvalid, bready, rready, Read_data_Valid, bus_err, bus_timeout, Mem_Req_Ready}, err_addr);
      end
   endtask

   task automatic test_timeout;
      int waits;
      bit seen;
      waits = 0;
      seen = 1'b0;
      arready = 1'b0;
      Address = 32'h3000_000C; MemRead = 1'b1;
      tick;
      MemRead = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (bus_timeout === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (arvalid === 1'b1) waits++;
            tick;
         end
      end
      checks++;
      if (seen !== 1'b1 || waits !== 16) begin
         errors++;
         $display("FAIL to_cycles got seen=%b waits=%0d want 1 16", seen, waits);
      end
      checks++;
      if ({arvalid, bus_err} !== 2'b10 || err_addr !== 32'h3000_000C) begin
         errors++;
         $display("FAIL to_state got %b %h want 10 3000000c", {arvalid, bus_err}, err_addr);
      end
      tick;
      checks++;
      if ({arvalid, bus_timeout} !== 2'b11) begin
         errors++;
         $display("FAIL to_hold got %b want 11", {arvalid, bus_timeout});
      end
      system_reset = 1'b1;
      tick;
      system_reset = 1'b0; arready = 1'b1;
      checks++;
      if ({arvalid, bus_timeout} !== 2'b00) begin
         errors++;
         $display("FAIL to_reset got %b want 00", {arvalid, bus_timeout});
      end
   endtask

   initial begin
      test_reset;
      test_write_zero_wait;
      test_write_wready_delay;
      test_read_hold;
      test_write_read_collision;
      test_bus_error;
      test_reset_mid_read;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
